// File: rtl/storage_load_sequencer.sv
// Load-command front end for data_path: turns accepted commands into storage write strobes,
// then sequences locator reset, code storage enable and controller enable after the last one.
module storage_load_sequencer #(
  parameter int LANE_WIDTH  = 16,
  parameter int LANES       = 3,
  parameter int FRAC_BITS   = 8,
  parameter int CODE_WIDTH  = 12,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_target,
  input  logic [31:0]                   cmd_layer,
  input  logic [31:0]                   cmd_row,
  input  logic [LANES*LANE_WIDTH-1:0]   cmd_data,
  input  logic                          cmd_last,
  input  logic                          halt,
  output logic [31:0]                   write_layer_index,
  output logic [31:0]                   write_row_index,
  output logic [LANES*LANE_WIDTH-1:0]   write_data,
  output logic                          weight_is_write,
  output logic                          input_is_write,
  output logic                          label_is_write,
  output logic [31:0]                   code_write_line,
  output logic [CODE_WIDTH-1:0]         code_write_data,
  output logic                          code_is_write,
  output logic                          locator_reset,
  output logic                          code_storage_enable,
  output logic                          controller_enable,
  output logic                          busy,
  output logic [COUNT_WIDTH-1:0]        write_count
);

  localparam int DATA_WIDTH = LANES * LANE_WIDTH;

  typedef enum logic [2:0] {
    ST_LOAD      = 3'd0,
    ST_DRAIN     = 3'd1,
    ST_LOC_RESET = 3'd2,
    ST_PRIME     = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  state_t                   state_r;
  state_t                   next_s;
  logic                     accept_s;
  logic                     halt_run_s;
  logic [31:0]              layer_r;
  logic [31:0]              row_r;
  logic [DATA_WIDTH-1:0]    data_r;
  logic [31:0]              code_line_r;
  logic [CODE_WIDTH-1:0]    code_word_r;
  logic                     weight_wr_r;
  logic                     input_wr_r;
  logic                     label_wr_r;
  logic                     code_wr_r;
  logic                     locator_reset_r;
  logic                     code_en_r;
  logic                     ctrl_en_r;
  logic                     busy_r;
  logic [COUNT_WIDTH-1:0]   count_r;

  // Q8.8 scaling: each lane shifted left and truncated back to lane width.
  function automatic logic [DATA_WIDTH-1:0] scale_lanes(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] res;
    res = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      res[i*LANE_WIDTH +: LANE_WIDTH] = d[i*LANE_WIDTH +: LANE_WIDTH] << FRAC_BITS;
    end
    return res;
  endfunction

  assign cmd_ready  = (state_r == ST_LOAD);
  assign accept_s   = cmd_valid && (state_r == ST_LOAD);
  assign halt_run_s = halt && (state_r == ST_RUN);

  // State register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state: load until the last command, then a fixed start-up walk into RUN.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (accept_s && cmd_last) next_s = ST_DRAIN;
        else                      next_s = ST_LOAD;
      end
      ST_DRAIN:     next_s = ST_LOC_RESET;
      ST_LOC_RESET: next_s = ST_PRIME;
      ST_PRIME:     next_s = ST_RUN;
      ST_RUN: begin
        if (halt) next_s = ST_LOAD;
        else      next_s = ST_RUN;
      end
      default:      next_s = ST_LOAD;
    endcase
  end

  // Write strobes, registered buses and the strobe counter.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      weight_wr_r <= 1'b0;
      input_wr_r  <= 1'b0;
      label_wr_r  <= 1'b0;
      code_wr_r   <= 1'b0;
      layer_r     <= 32'd0;
      row_r       <= 32'd0;
      data_r      <= {DATA_WIDTH{1'b0}};
      code_line_r <= 32'd0;
      code_word_r <= {CODE_WIDTH{1'b0}};
      count_r     <= {COUNT_WIDTH{1'b0}};
    end else begin
      weight_wr_r <= accept_s && (cmd_target == 2'd0);
      input_wr_r  <= accept_s && (cmd_target == 2'd1);
      label_wr_r  <= accept_s && (cmd_target == 2'd2);
      code_wr_r   <= accept_s && (cmd_target == 2'd3);
      if (accept_s && (cmd_target == 2'd3)) begin
        code_line_r <= cmd_row;
        code_word_r <= cmd_data[CODE_WIDTH-1:0];
      end else if (accept_s) begin
        layer_r <= cmd_layer;
        row_r   <= cmd_row;
        data_r  <= (cmd_target == 2'd0) ? cmd_data : scale_lanes(cmd_data);
      end else begin
        layer_r <= layer_r;
      end
      if (halt_run_s) begin
        count_r <= {COUNT_WIDTH{1'b0}};
      end else if (accept_s && (count_r != {COUNT_WIDTH{1'b1}})) begin
        count_r <= count_r + COUNT_WIDTH'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Sequencing outputs registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      locator_reset_r <= 1'b0;
      code_en_r       <= 1'b0;
      ctrl_en_r       <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      locator_reset_r <= (next_s == ST_LOC_RESET);
      code_en_r       <= (next_s == ST_PRIME) || (next_s == ST_RUN);
      ctrl_en_r       <= (next_s == ST_RUN);
      busy_r          <= (next_s != ST_LOAD);
    end
  end

  assign write_layer_index   = layer_r;
  assign write_row_index     = row_r;
  assign write_data          = data_r;
  assign weight_is_write     = weight_wr_r;
  assign input_is_write      = input_wr_r;
  assign label_is_write      = label_wr_r;
  assign code_write_line     = code_line_r;
  assign code_write_data     = code_word_r;
  assign code_is_write       = code_wr_r;
  assign locator_reset       = locator_reset_r;
  assign code_storage_enable = code_en_r;
  assign controller_enable   = ctrl_en_r;
  assign busy                = busy_r;
  assign write_count         = count_r;

endmodule

// File: tb/tb_storage_load_sequencer.sv
// Bench for storage_load_sequencer: directed test-plan steps plus randomized commands,
// all checked every cycle against a cycle-age reference model.
module tb_storage_load_sequencer;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_target;
  logic [31:0] cmd_layer;
  logic [31:0] cmd_row;
  logic [47:0] cmd_data;
  logic        cmd_last;
  logic        halt;
  logic [31:0] write_layer_index;
  logic [31:0] write_row_index;
  logic [47:0] write_data;
  logic        weight_is_write;
  logic        input_is_write;
  logic        label_is_write;
  logic [31:0] code_write_line;
  logic [11:0] code_write_data;
  logic        code_is_write;
  logic        locator_reset;
  logic        code_storage_enable;
  logic        controller_enable;
  logic        busy;
  logic [15:0] write_count;

  int checks = 0;
  int errors = 0;

  // model: age = edges since the cmd_last accept (-1 while loading)
  int          m_age;
  logic [3:0]  m_strobe;
  logic [31:0] m_layer, m_row, m_line;
  logic [47:0] m_data;
  logic [11:0] m_word;
  int          m_count;

  storage_load_sequencer dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
    .cmd_layer(cmd_layer), .cmd_row(cmd_row), .cmd_data(cmd_data),
    .cmd_last(cmd_last), .halt(halt),
    .write_layer_index(write_layer_index), .write_row_index(write_row_index),
    .write_data(write_data), .weight_is_write(weight_is_write),
    .input_is_write(input_is_write), .label_is_write(label_is_write),
    .code_write_line(code_write_line), .code_write_data(code_write_data),
    .code_is_write(code_is_write), .locator_reset(locator_reset),
    .code_storage_enable(code_storage_enable), .controller_enable(controller_enable),
    .busy(busy), .write_count(write_count)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] q88(input logic [47:0] d);
    logic [47:0] r;
    int unsigned v;
    for (int i = 0; i < 3; i++) begin
      v = d[i*16 +: 16];
      v = (v * 256) % 65536;
      r[i*16 +: 16] = v[15:0];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_age = -1; m_strobe = 4'b0000; m_layer = 32'd0; m_row = 32'd0;
    m_line = 32'd0; m_data = 48'd0; m_word = 12'd0; m_count = 0;
  endtask

  task automatic model_edge();
    m_strobe = 4'b0000;
    if (cmd_valid && (m_age < 0)) begin
      m_strobe[cmd_target] = 1'b1;
      if (cmd_target == 2'd3) begin
        m_line = cmd_row;
        m_word = cmd_data[11:0];
      end else begin
        m_layer = cmd_layer;
        m_row   = cmd_row;
        m_data  = (cmd_target == 2'd0) ? cmd_data : q88(cmd_data);
      end
      if (m_count < 65535) m_count++;
      if (cmd_last) m_age = 1;
    end else if (m_age >= 4 && halt) begin
      m_age = -1;
      m_count = 0;
    end else if (m_age >= 1 && m_age < 1000) begin
      m_age++;
    end
  endtask

  task automatic compare();
    check("cmd_ready", cmd_ready, (m_age < 0));
    check("busy", busy, (m_age >= 0));
    check("weight_is_write", weight_is_write, m_strobe[0]);
    check("input_is_write", input_is_write, m_strobe[1]);
    check("label_is_write", label_is_write, m_strobe[2]);
    check("code_is_write", code_is_write, m_strobe[3]);
    check("locator_reset", locator_reset, (m_age == 2));
    check("code_storage_enable", code_storage_enable, (m_age >= 3));
    check("controller_enable", controller_enable, (m_age >= 4));
    check("write_layer_index", write_layer_index, m_layer);
    check("write_row_index", write_row_index, m_row);
    check("write_data", write_data, m_data);
    check("code_write_line", code_write_line, m_line);
    check("code_write_data", code_write_data, m_word);
    check("write_count", write_count, m_count);
  endtask

  task automatic step(input logic v, input logic [1:0] t, input logic [31:0] l, input logic [31:0] r,
                      input logic [47:0] d, input logic last, input logic h);
    cmd_valid = v; cmd_target = t; cmd_layer = l; cmd_row = r;
    cmd_data = d; cmd_last = last; halt = h;
    @(posedge clk_clk);
    model_edge();
    @(negedge clk_clk);
    compare();
  endtask

  task automatic async_reset(input string tag);
    #1 reset_reset_n = 1'b0;
    #1;
    check({tag, "_locator_async"}, locator_reset, 1'b0);
    check({tag, "_ctrl_en_async"}, controller_enable, 1'b0);
    check({tag, "_code_en_async"}, code_storage_enable, 1'b0);
    model_reset();
    compare();
    @(posedge clk_clk);
    @(negedge clk_clk);
    compare();
    reset_reset_n = 1'b1;
  endtask

  initial begin
    logic [63:0] rd;
    reset_reset_n = 1'b0;
    step_idle_init: begin
      cmd_valid = 1'b0; cmd_target = 2'd0; cmd_layer = 32'd0; cmd_row = 32'd0;
      cmd_data = 48'd0; cmd_last = 1'b0; halt = 1'b0;
    end
    model_reset();
    @(negedge clk_clk);
    compare();
    check("reset_cmd_ready", cmd_ready, 1'b1);
    reset_reset_n = 1'b1;

    // 1: single weight command
    step(1'b1, 2'd0, 32'd2, 32'd5, {16'd3, 16'hFFFE, 16'd7}, 1'b0, 1'b0);
    check("t1_weight_strobe", weight_is_write, 1'b1);
    check("t1_data", write_data, 48'h0003_FFFE_0007);
    check("t1_layer", write_layer_index, 32'd2);
    check("t1_row", write_row_index, 32'd5);
    check("t1_count", write_count, 16'd1);
    step(1'b0, 2'd0, 32'd0, 32'd0, 48'd0, 1'b0, 1'b0);
    check("t1_strobe_once", weight_is_write, 1'b0);
    check("t1_bus_hold", write_data, 48'h0003_FFFE_0007);

    // 2: input then label back-to-back
    step(1'b1, 2'd1, 32'd1, 32'd1, {16'd1, 16'hFFFF, 16'h0180}, 1'b0, 1'b0);
    check("t2_input_strobe", input_is_write, 1'b1);
    check("t2_input_data", write_data, 48'h0100_FF00_8000);
    check("t2_ready", cmd_ready, 1'b1);
    step(1'b1, 2'd2, 32'd1, 32'd2, {16'd2, 16'd0, 16'hFFFF}, 1'b0, 1'b0);
    check("t2_label_strobe", label_is_write, 1'b1);
    check("t2_input_drop", input_is_write, 1'b0);
    check("t2_label_data", write_data, 48'h0200_0000_FF00);
    check("t2_count", write_count, 16'd3);

    // 3/4: last code command, valid held high and halt ignored during start-up
    step(1'b1, 2'd3, 32'd7, 32'd9, 48'h0000_0000_0ABC, 1'b1, 1'b0);
    check("t3_code_strobe", code_is_write, 1'b1);
    check("t3_code_line", code_write_line, 32'd9);
    check("t3_code_word", code_write_data, 12'hABC);
    check("t3_bus_untouched", write_data, 48'h0200_0000_FF00);
    check("t3_no_loc_yet", locator_reset, 1'b0);
    step(1'b1, 2'd0, 32'd0, 32'd0, 48'd1, 1'b0, 1'b1);
    check("t3_loc_reset", locator_reset, 1'b1);
    check("t3_code_en_early", code_storage_enable, 1'b0);
    step(1'b1, 2'd0, 32'd0, 32'd0, 48'd1, 1'b0, 1'b1);
    check("t3_prime_code_en", code_storage_enable, 1'b1);
    check("t3_prime_ctrl_en", controller_enable, 1'b0);
    check("t3_loc_once", locator_reset, 1'b0);
    step(1'b1, 2'd0, 32'd0, 32'd0, 48'd1, 1'b0, 1'b0);
    check("t3_run_ctrl_en", controller_enable, 1'b1);
    step(1'b1, 2'd1, 32'd0, 32'd0, 48'd1, 1'b0, 1'b0);
    check("t4_ready_low", cmd_ready, 1'b0);
    check("t4_no_strobe", input_is_write, 1'b0);
    check("t4_count_held", write_count, 16'd4);

    // 5: halt returns to LOAD
    step(1'b0, 2'd0, 32'd0, 32'd0, 48'd0, 1'b0, 1'b1);
    check("t5_ctrl_off", controller_enable, 1'b0);
    check("t5_code_off", code_storage_enable, 1'b0);
    check("t5_ready", cmd_ready, 1'b1);
    check("t5_count_clear", write_count, 16'd0);
    step(1'b1, 2'd0, 32'd3, 32'd4, 48'h0001_0002_0003, 1'b0, 1'b0);
    check("t5_new_strobe", weight_is_write, 1'b1);
    check("t5_new_count", write_count, 16'd1);

    // 6: async reset in LOC_RESET, then in RUN
    step(1'b1, 2'd0, 32'd1, 32'd1, 48'd5, 1'b1, 1'b0);
    step(1'b0, 2'd0, 32'd0, 32'd0, 48'd0, 1'b0, 1'b0);
    check("t6_in_loc_reset", locator_reset, 1'b1);
    async_reset("t6a");
    step(1'b1, 2'd2, 32'd1, 32'd1, 48'd5, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 32'd0, 32'd0, 48'd0, 1'b0, 1'b0);
    check("t6_in_run", controller_enable, 1'b1);
    async_reset("t6b");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rd = {$urandom, $urandom};
      step($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), $urandom, $urandom,
           rd[47:0], $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/storage_load_sequencer.md
Name: storage_load_sequencer

Overview:
- Front-end controller for data_path.
- Accepts a valid/ready stream of load commands and converts each into a one-cycle write strobe with registered address and data on the weight, input, label or code storage write interface.
- Applies Q8.8 scaling to input and label lanes.
- After the last command: pulses matrix_storage_locator reset, then enables code storage, then the controller one cycle later. This is the start-up order data_path requires.

Parameters:
LANE_WIDTH, 16, width of one signed data lane
LANES, 3, lanes per storage row (data bus = LANES*LANE_WIDTH = 48)
FRAC_BITS, 8, left shift applied to input/label lanes (Q8.8)
CODE_WIDTH, 12, code storage word width
COUNT_WIDTH, 16, width of write_count

Ports:
clk_clk  in  1  clock, all state on rising edge
reset_reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid & ready at clock edge
cmd_target  in  2  0 weight, 1 input, 2 label, 3 code
cmd_layer  in  32  layer index (ignored for code)
cmd_row  in  32  row index; code line for target 3
cmd_data  in  48  lanes {lane2,lane1,lane0}, lane2 in [47:32]; code uses [11:0]
cmd_last  in  1  final load command; starts run sequence
halt  in  1  end run, return to LOAD
write_layer_index  out  32  shared registered layer bus
write_row_index  out  32  shared registered row bus
write_data  out  48  shared registered data bus (scaled as below)
weight_is_write  out  1  weight storage strobe
input_is_write  out  1  input storage strobe
label_is_write  out  1  label storage strobe
code_write_line  out  32  code storage line
code_write_data  out  12  code storage word
code_is_write  out  1  code storage strobe
locator_reset  out  1  matrix_storage_locator reset pulse
code_storage_enable  out  1  code storage enable
controller_enable  out  1  controller enable
busy  out  1  high in every state except LOAD
write_count  out  16  number of strobes issued since last entry to LOAD from reset/halt

Behaviour:
- Reset (async, immediate): all outputs 0 except cmd_ready=1; state=LOAD; write_count=0.
- States: LOAD, DRAIN, LOC_RESET, PRIME, RUN.
- cmd_ready = (state==LOAD). Combinational from state only; never from cmd_valid.
- LOAD, accept at edge N:
  - Exactly one strobe for cmd_target is high during cycle N+1.
  - Buses are registered at edge N and hold their value until the next accept.
  - Back-to-back accepts give one strobe per cycle.
  - With no accept, all strobes are 0 the following cycle.
- Scaling, per 16-bit lane:
  - weight: passthrough.
  - input, label: lane << FRAC_BITS, truncated to 16 bits (e.g. 1 -> 0x0100, -1 -> 0xFF00, 0x0180 -> 0x8000).
  - code: code_write_data = cmd_data[11:0], code_write_line = cmd_row. write_* buses are not updated.
- write_count: increments once per strobe and saturates at all-ones.
- Accept with cmd_last=1 (edge N):
  - The strobe for that command is still issued in cycle N+1 (state DRAIN).
  - LOC_RESET in N+2: locator_reset=1 for exactly that cycle.
  - PRIME in N+3: code_storage_enable=1, controller_enable=0.
  - RUN from N+4: code_storage_enable=1, controller_enable=1.
- RUN:
  - Persists until halt=1 is sampled at an edge. Then state=LOAD, both enables 0 from the next cycle, write_count cleared.
  - halt is ignored in DRAIN/LOC_RESET/PRIME; it is re-sampled in RUN.
  - cmd_valid is ignored in every non-LOAD state. No accept occurs and no strobe is issued.
- cmd_last with zero prior commands is legal: one strobe, then the normal sequence.
- Reset asserted mid-strobe or mid-RUN: strobes and enables drop asynchronously and the sequence restarts from LOAD.

Test Plan:
1. Reset, then 1 weight cmd (layer 2, row 5, data {3,-2,7}) -> weight_is_write high exactly 1 cycle; write_data=0x0003_FFFE_0007; layer=2, row=5; write_count=1.
2. Input cmd data {1,-1,0x0180}, then label cmd back-to-back -> input strobe with data 0x0100_FF00_8000; label strobe the next cycle; no idle cycle between them; cmd_ready stays 1.
3. Code cmd row 9, data 0x...ABC with cmd_last -> code_is_write in N+1 with line 9/word 0xABC; locator_reset only in N+2; code_storage_enable from N+3; controller_enable from N+4.
4. cmd_valid held high during RUN -> cmd_ready=0; no strobes; write_count unchanged.
5. halt pulse in RUN -> enables 0 next cycle; cmd_ready=1; write_count=0. A new cmd is then accepted normally.
6. reset_reset_n low in LOC_RESET and again in RUN -> locator_reset and enables fall immediately, without a clock edge. After release: state LOAD, all strobes 0.
